// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM states, request opcode and default widths.
package mem_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 16;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StWait = 2'b01,
        StResp = 2'b10
    } state_e;

    typedef enum logic {
        OpRd = 1'b0,
        OpWr = 1'b1
    } op_e;

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port RAM with write enable, read enable and a registered read port.
// Contents are never reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one read/write at a time, waits LATENCY cycles, then pulses ready
// (and err on a faulted or out-of-range request). RAM access happens on the edge entering RESP.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int unsigned     AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      Lat      = 4'(LATENCY);

    if (LATENCY > 15) begin : g_latency_check
        $error("mem_responder: LATENCY must be in 0..15");
    end

    state_e            state_q;
    logic [3:0]        cnt_q;
    op_e               op_q;
    logic              fault_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ready_q;
    logic              err_q;
    logic              rd_zero_q;

    logic              cur_valid;
    logic              cur_fault;
    op_e               cur_op;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              in_range;
    logic              commit;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] ram_rdata;

    // In IDLE with LATENCY=0 the access happens on the acceptance edge, so use the live inputs.
    always_comb begin
        cur_valid = 1'b0;
        cur_fault = fault_q;
        cur_op    = op_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state_q == StIdle) begin
            cur_valid = mem_read | mem_write;
            cur_fault = mem_read & mem_write;
            cur_op    = mem_write ? OpWr : OpRd;
            cur_addr  = addr;
            cur_wdata = wdata;
        end
    end

    always_comb begin
        in_range = ({1'b0, cur_addr} < DepthLim);
        commit   = 1'b0;
        unique case (state_q)
            StIdle:  commit = cur_valid && (Lat == 4'd0);
            StWait:  commit = (cnt_q == 4'd1);
            default: commit = 1'b0;
        endcase
        ram_we = commit && !cur_fault && in_range && (cur_op == OpWr);
        ram_re = commit && !cur_fault && in_range && (cur_op == OpRd);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            op_q      <= OpRd;
            fault_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rd_zero_q <= 1'b1;
        end else begin
            ready_q <= commit;
            err_q   <= commit && (cur_fault || !in_range);
            // Out-of-range reads zero rdata; in-range reads expose the RAM output register.
            if (commit && !cur_fault && !in_range && (cur_op == OpRd)) begin
                rd_zero_q <= 1'b1;
            end else if (ram_re) begin
                rd_zero_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (cur_valid) begin
                        op_q    <= cur_op;
                        fault_q <= cur_fault;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt_q   <= Lat;
                        state_q <= (Lat == 4'd0) ? StResp : StWait;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem_array (
        .clk_i   (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (cur_addr[AW-1:0]),
        .wdata_i (cur_wdata),
        .rdata_o (ram_rdata)
    );

    assign rdata = rd_zero_q ? '0 : ram_rdata;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = (state_q != StIdle);

endmodule
